standoff_press_arbiter: RTL and testbench
=========================================

// Module: standoff_press_arbiter
// PURPOSE
//   Consumer end of the debounced key interface: takes the two stable
//   player key levels, detects press edges and referees one standoff round.
//   After a start pulse it waits a fixed arming delay, raises the draw
//   signal, and reports the winner, false start or tie, with reaction time.
//   Sits between the keyboard debouncer outputs and the game display/score logic.
// PARAMETERS
//   DELAY_CYCLES    8'd? -> default 50_000_000  cycles from WAIT entry to draw
//   TIMEOUT_CYCLES  default 100_000_000         max GO cycles before no-winner
//   CNT_W           default 32                  width of internal counters/react_cycles
// PORTS
//   clk           in   1      system clock, all logic on rising edge
//   rst           in   1      asynchronous, active-high reset
//   start         in   1      round start request, sampled each cycle
//   p0_key        in   1      player 0 debounced key level (1 = pressed)
//   p1_key        in   1      player 1 debounced key level (1 = pressed)
//   busy          out  1      1 in WAIT or GO
//   draw          out  1      1 only in GO (the "draw now" cue)
//   result_valid  out  1      1-cycle pulse on entry to DONE
//   winner        out  2      00 none/timeout, 01 p0, 10 p1, 11 tie; held in DONE
//   false_start   out  1      1 if result decided by a press during WAIT; held in DONE
//   react_cycles  out  CNT_W  GO cycles elapsed before winning edge; held in DONE
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; all outputs 0; counters 0;
//     key history regs p0_q/p1_q = 0.
//   - Edge detect: p0_q<=p0_key, p1_q<=p1_key every cycle in every state;
//     e0 = p0_key & ~p0_q, e1 = p1_key & ~p1_q. Only rising edges count;
//     a key held across start never registers until released and re-pressed.
//   - All outputs registered; decisions take effect at the clock edge
//     ending the cycle in which the event is seen (1-cycle latency).
//   - IDLE: edges ignored. start=1 -> WAIT, delay counter=0.
//   - WAIT: busy=1. Delay counter increments each cycle.
//       e0&e1 -> DONE, winner=11, false_start=1.
//       e0 only -> DONE, winner=10 (p1 wins), false_start=1.
//       e1 only -> DONE, winner=01, false_start=1.
//       no edge and counter==DELAY_CYCLES-1 -> GO, react counter=0.
//     draw therefore rises exactly DELAY_CYCLES cycles after WAIT entry.
//   - GO: busy=1, draw=1. React counter increments each cycle.
//       e0&e1 same cycle -> DONE, winner=11.
//       e0 only -> winner=01; e1 only -> winner=10.
//       react_cycles = counter value in the edge cycle (0 if first GO cycle).
//       no edge and counter==TIMEOUT_CYCLES-1 -> DONE, winner=00,
//       react_cycles=TIMEOUT_CYCLES.
//     Press edge takes priority over timeout in the same cycle.
//   - DONE: busy=0, draw=0, result_valid=1 only on first DONE cycle;
//     winner/false_start/react_cycles held. start=1 -> clear results, WAIT.
//   - start ignored in WAIT and GO (no restart mid-round).
//   - Counters saturate never needed: exit conditions reached before wrap;
//     DELAY_CYCLES, TIMEOUT_CYCLES must be >=1 and < 2**CNT_W.
//   - Reset mid-round: immediate return to IDLE, draw drops asynchronously,
//     no result_valid pulse.
// TESTING  (bench uses DELAY_CYCLES=8, TIMEOUT_CYCLES=16)
//   - Clean win: start 1 cycle; p1 rises 3 cycles after draw rises -> one
//     result_valid pulse, winner=10, false_start=0, react_cycles=3, draw=0.
//   - False start: p0 rises 4 cycles after start -> DONE next edge, winner=10,
//     false_start=1, draw never asserted.
//   - Tie: p0 and p1 rise same cycle in GO -> winner=11, false_start=0.
//   - Timeout: no presses -> draw high exactly 16 cycles, then winner=00,
//     react_cycles=16, result_valid pulse.
//   - Held key: p0 held high from before start through GO, p1 pressed 5 cycles
//     into GO -> winner=10 (held key ignored); start during GO has no effect.
//   - Reset mid-GO: assert rst between clocks -> draw/busy drop at once, state
//     IDLE, no result_valid; next start runs a full normal round.

Source files
------------

// File: rtl/standoff_press_arbiter.sv
// Referee for one two-player standoff round: an arming delay, then a draw cue,
// then the first rising key edge wins. Reports false starts, ties and timeouts.
module standoff_press_arbiter #(
    parameter int DELAY_CYCLES   = 50_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             p0_key,
    input  logic             p1_key,
    output logic             busy,
    output logic             draw,
    output logic             result_valid,
    output logic [1:0]       winner,
    output logic             false_start,
    output logic [CNT_W-1:0] react_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_p0_q;
    logic             r_p1_q;
    logic             w_e0;
    logic             w_e1;

    // Only fresh presses count, so a key held across start stays invisible.
    assign w_e0 = p0_key & ~r_p0_q;
    assign w_e1 = p1_key & ~r_p1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_p0_q       <= 1'b0;
            r_p1_q       <= 1'b0;
            busy         <= 1'b0;
            draw         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= 2'b00;
            false_start  <= 1'b0;
            react_cycles <= '0;
        end else begin
            r_p0_q       <= p0_key;
            r_p1_q       <= p1_key;
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_e0 | w_e1) begin
                        // Jumping the gun hands the round to the other player.
                        r_state      <= S_DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        false_start  <= 1'b1;
                        winner       <= {w_e0, w_e1};
                    end else if (r_cnt == DELAY_LAST) begin
                        r_state <= S_GO;
                        r_cnt   <= '0;
                        draw    <= 1'b1;
                    end
                end
                S_GO: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_e0 | w_e1) begin
                        r_state      <= S_DONE;
                        busy         <= 1'b0;
                        draw         <= 1'b0;
                        result_valid <= 1'b1;
                        winner       <= {w_e1, w_e0};
                        react_cycles <= r_cnt;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state      <= S_DONE;
                        busy         <= 1'b0;
                        draw         <= 1'b0;
                        result_valid <= 1'b1;
                        winner       <= 2'b00;
                        react_cycles <= TIMEOUT_VAL;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state      <= S_WAIT;
                        r_cnt        <= '0;
                        busy         <= 1'b1;
                        winner       <= 2'b00;
                        false_start  <= 1'b0;
                        react_cycles <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_standoff_press_arbiter.sv
// Randomised rounds of the standoff referee, checked by a scoreboard fed from
// a press-time reference model and drained by an independent result monitor.
module tb_standoff_press_arbiter;

    localparam int D     = 8;
    localparam int T     = 16;
    localparam int CNT_W = 32;
    localparam int INF   = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             p0_key = 1'b0;
    logic             p1_key = 1'b0;
    logic             busy;
    logic             draw;
    logic             result_valid;
    logic [1:0]       winner;
    logic             false_start;
    logic [CNT_W-1:0] react_cycles;

    typedef struct {
        int w;
        int fs;
        int react;
        int drawc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   draw_cnt = 0;

    standoff_press_arbiter #(
        .DELAY_CYCLES  (D),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .p0_key      (p0_key),
        .p1_key      (p1_key),
        .busy        (busy),
        .draw        (draw),
        .result_valid(result_valid),
        .winner      (winner),
        .false_start (false_start),
        .react_cycles(react_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Round outcome from the cycle (counted from the first WAIT cycle) at
    // which each player's fresh press appears; INF means no press.
    task automatic model(input int t0, input int t1, output exp_t e, output int endc);
        int t;
        t = (t0 < t1) ? t0 : t1;
        if (t < D) begin
            e.fs = 1; e.react = 0; e.drawc = 0; endc = t;
            e.w  = (t0 == t1) ? 3 : ((t0 == t) ? 2 : 1);
        end else if (t < D + T) begin
            e.fs = 0; e.react = t - D; e.drawc = t - D + 1; endc = t;
            e.w  = (t0 == t1) ? 3 : ((t0 == t) ? 1 : 2);
        end else begin
            e.fs = 0; e.react = T; e.drawc = T; e.w = 0; endc = D + T - 1;
        end
    endtask

    task automatic run_round(input int t0, input int t1, input bit hold0,
                             input bit poke, input int rst_at);
        exp_t e;
        int   endc;
        bit   was_reset;
        was_reset = 1'b0;
        model(hold0 ? INF : t0, t1, e, endc);
        if (hold0) begin
            p0_key = 1'b1;
            @(posedge clk); #1;
        end
        if (rst_at < 0) sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("wait_entry_busy", busy, 1);
        chk("wait_entry_cleared", {winner, false_start} | react_cycles, 0);
        for (int c = 0; c <= endc; c++) begin
            if (rst_at == c) begin
                rst = 1'b1;
                #1;
                chk("rst_async_draw_busy", {draw, busy, result_valid}, 0);
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b0;
                was_reset = 1'b1;
                break;
            end
            if (!hold0 && t0 <= c) p0_key = 1'b1;
            if (t1 <= c) p1_key = 1'b1;
            start = (poke && c == endc - 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 0);
        if (!was_reset) begin
            @(posedge clk); #1;
            chk("rv_single_pulse", result_valid, 0);
            chk("winner_held", winner, e.w);
        end else begin
            chk("idle_after_rst", {busy, draw, result_valid}, 0);
        end
        p0_key = 1'b0;
        p1_key = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                draw_cnt = 0;
            end else begin
                if (result_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        $display("result: winner=%0d fs=%0d react=%0d draw_cycles=%0d (exp %0d %0d %0d %0d)",
                                 winner, false_start, react_cycles, draw_cnt,
                                 e.w, e.fs, e.react, e.drawc);
                        chk("winner", winner, e.w);
                        chk("false_start", false_start, e.fs);
                        chk("react_cycles", react_cycles, e.react);
                        chk("draw_cycles", draw_cnt, e.drawc);
                        chk("done_busy_draw", {busy, draw}, 0);
                    end
                    draw_cnt = 0;
                end
                if (draw) draw_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        bit h;
        #1;
        chk("reset_outputs", {busy, draw, result_valid, winner, false_start} | react_cycles, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ignores_keys", busy, 0);

        run_round(INF, D + 3, 1'b0, 1'b0, -1);   // clean win by p1, react 3
        run_round(3, INF, 1'b0, 1'b0, -1);       // p0 false start
        run_round(D + 5, D + 5, 1'b0, 1'b0, -1); // tie in GO
        run_round(2, 2, 1'b0, 1'b0, -1);         // tie false start
        run_round(INF, INF, 1'b0, 1'b0, -1);     // timeout
        run_round(INF, D + 5, 1'b1, 1'b1, -1);   // held p0, start poked in GO
        run_round(D, INF, 1'b0, 1'b0, -1);       // press on first GO cycle
        run_round(D + T - 1, INF, 1'b0, 1'b0, -1); // press beats timeout
        run_round(INF, INF, 1'b0, 1'b0, D + 3);  // reset mid-GO
        run_round(INF, D + 2, 1'b0, 1'b0, -1);   // full round after reset

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 3) == 0) ? INF : int'($urandom_range(0, D + T + 2));
            b = ($urandom_range(0, 3) == 0) ? INF : int'($urandom_range(0, D + T + 2));
            h = (a == INF) && ($urandom_range(0, 2) == 0);
            run_round(a, b, h, 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
